// File: rtl/axil_master_arbiter_pkg.sv
// Shared types and defaults for the AXI-Lite master arbiter.
package axil_master_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/axil_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant_c,
    output logic [PTR_W-1:0] o_idx_c
);

    always_comb begin
        int unsigned pos;
        logic        found;
        o_grant_c = '0;
        o_idx_c   = '0;
        found     = 1'b0;
        pos       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = 32'(i_ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (!found && i_req[PTR_W'(pos)]) begin
                found                    = 1'b1;
                o_idx_c                  = PTR_W'(pos);
                o_grant_c[PTR_W'(pos)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_master_arbiter.sv
// Round-robin arbiter serialising single-beat requester commands onto one AXI-Lite master port.
module axil_master_arbiter
    import axil_master_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                      M_AXI_ACLK,
    input  logic                      M_AXI_ARESET,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          req_done,
    output logic                      req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         M_AXI_LITE_AWADDR,
    output logic                      M_AXI_LITE_AWVALID,
    input  logic                      M_AXI_LITE_AWREADY,
    output logic [DATA_W-1:0]         M_AXI_LITE_WDATA,
    output logic                      M_AXI_LITE_WVALID,
    input  logic                      M_AXI_LITE_WREADY,
    input  logic                      M_AXI_LITE_BVALID,
    output logic                      M_AXI_LITE_BREADY,
    output logic [ADDR_W-1:0]         M_AXI_LITE_ARADDR,
    output logic                      M_AXI_LITE_ARVALID,
    input  logic                      M_AXI_LITE_ARREADY,
    input  logic                      M_AXI_LITE_RVALID,
    output logic                      M_AXI_LITE_RREADY,
    input  logic [DATA_W-1:0]         M_AXI_LITE_RDATA
);

    localparam int unsigned PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W_MIN = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W     = (CNT_W_MIN > 8) ? CNT_W_MIN : 8;

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]    r_gnt_oh, w_gnt_oh_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_wdata, w_wdata_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                r_awvalid, w_awvalid_nxt;
    logic                r_wvalid, w_wvalid_nxt;
    logic                r_bready, w_bready_nxt;
    logic                r_arvalid, w_arvalid_nxt;
    logic                r_rready, w_rready_nxt;
    logic [N_REQ-1:0]    r_done, w_done_nxt;
    logic                r_err, w_err_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
    logic                r_busy;
    logic                w_tmo, w_aw_fin, w_w_fin;
    logic [N_REQ-1:0]    w_gnt_oh;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [ADDR_W-1:0]   w_req_addr  [N_REQ];
    logic [DATA_W-1:0]   w_req_wdata [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_req_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_req_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_grant_c (w_gnt_oh),
        .o_idx_c   (w_gnt_idx)
    );

    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_tmo     = (w_cnt_inc == CNT_W'(TIMEOUT));
    // A channel is finished once its VALID has dropped or is being accepted this cycle.
    assign w_aw_fin  = !r_awvalid || M_AXI_LITE_AWREADY;
    assign w_w_fin   = !r_wvalid  || M_AXI_LITE_WREADY;

    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gnt_oh_nxt  = r_gnt_oh;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_cnt_nxt     = r_cnt;
        w_awvalid_nxt = r_awvalid;
        w_wvalid_nxt  = r_wvalid;
        w_bready_nxt  = r_bready;
        w_arvalid_nxt = r_arvalid;
        w_rready_nxt  = r_rready;
        w_done_nxt    = '0;
        w_err_nxt     = 1'b0;
        w_rdata_nxt   = '0;

        case (r_state)
            IDLE: begin
                if (|req_valid) begin
                    w_gnt_oh_nxt = w_gnt_oh;
                    w_addr_nxt   = w_req_addr[w_gnt_idx];
                    w_wdata_nxt  = w_req_wdata[w_gnt_idx];
                    w_cnt_nxt    = '0;
                    w_ptr_nxt    = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
                    if (req_we[w_gnt_idx]) begin
                        w_state_nxt   = WR_ADDR;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = RD_ADDR;
                        w_arvalid_nxt = 1'b1;
                        w_rready_nxt  = 1'b1;
                    end
                end
            end
            WR_ADDR: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_awvalid && M_AXI_LITE_AWREADY) w_awvalid_nxt = 1'b0;
                if (r_wvalid && M_AXI_LITE_WREADY)   w_wvalid_nxt  = 1'b0;
                if (w_aw_fin && w_w_fin) begin
                    w_state_nxt  = WR_RESP;
                    w_bready_nxt = 1'b1;
                end else if (w_tmo) begin
                    w_state_nxt   = DONE;
                    w_awvalid_nxt = 1'b0;
                    w_wvalid_nxt  = 1'b0;
                    w_done_nxt    = r_gnt_oh;
                    w_err_nxt     = 1'b1;
                end
            end
            WR_RESP: begin
                w_cnt_nxt = w_cnt_inc;
                if (M_AXI_LITE_BVALID) begin
                    w_state_nxt  = DONE;
                    w_bready_nxt = 1'b0;
                    w_done_nxt   = r_gnt_oh;
                end else if (w_tmo) begin
                    w_state_nxt  = DONE;
                    w_bready_nxt = 1'b0;
                    w_done_nxt   = r_gnt_oh;
                    w_err_nxt    = 1'b1;
                end
            end
            RD_ADDR: begin
                w_cnt_nxt = w_cnt_inc;
                if (r_arvalid && M_AXI_LITE_ARREADY) w_arvalid_nxt = 1'b0;
                if (M_AXI_LITE_RVALID) begin
                    w_state_nxt   = DONE;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b0;
                    w_done_nxt    = r_gnt_oh;
                    w_rdata_nxt   = M_AXI_LITE_RDATA;
                end else if (w_tmo) begin
                    w_state_nxt   = DONE;
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b0;
                    w_done_nxt    = r_gnt_oh;
                    w_err_nxt     = 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt   = IDLE;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt_oh  <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cnt     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_done    <= '0;
            r_err     <= 1'b0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gnt_oh  <= w_gnt_oh_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_cnt     <= w_cnt_nxt;
            r_awvalid <= w_awvalid_nxt;
            r_wvalid  <= w_wvalid_nxt;
            r_bready  <= w_bready_nxt;
            r_arvalid <= w_arvalid_nxt;
            r_rready  <= w_rready_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_rdata   <= w_rdata_nxt;
            r_busy    <= (w_state_nxt != IDLE);
        end
    end

    assign req_done           = r_done;
    assign req_err            = r_err;
    assign req_rdata          = r_rdata;
    assign busy               = r_busy;
    assign M_AXI_LITE_AWADDR  = r_addr;
    assign M_AXI_LITE_ARADDR  = r_addr;
    assign M_AXI_LITE_WDATA   = r_wdata;
    assign M_AXI_LITE_AWVALID = r_awvalid;
    assign M_AXI_LITE_WVALID  = r_wvalid;
    assign M_AXI_LITE_BREADY  = r_bready;
    assign M_AXI_LITE_ARVALID = r_arvalid;
    assign M_AXI_LITE_RREADY  = r_rready;

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Directed bench for axil_master_arbiter with a small configurable AXI-Lite slave model.
module tb_axil_master_arbiter;

    localparam int N = 4;

    logic          clk, rst;
    logic [N-1:0]  req_valid, req_we;
    logic [N*32-1:0] req_addr, req_wdata;
    logic [N-1:0]  req_done;
    logic          req_err, busy;
    logic [31:0]   req_rdata;
    logic [31:0]   awaddr, wdata, araddr;
    logic          awvalid, wvalid, bready, arvalid, rready;
    logic          s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [31:0]   s_rdata;

    int checks, failures, cyc;

    axil_master_arbiter #(.N_REQ(N), .ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) dut (
        .M_AXI_ACLK         (clk),
        .M_AXI_ARESET       (rst),
        .req_valid          (req_valid),
        .req_we             (req_we),
        .req_addr           (req_addr),
        .req_wdata          (req_wdata),
        .req_done           (req_done),
        .req_err            (req_err),
        .req_rdata          (req_rdata),
        .busy               (busy),
        .M_AXI_LITE_AWADDR  (awaddr),
        .M_AXI_LITE_AWVALID (awvalid),
        .M_AXI_LITE_AWREADY (s_awready),
        .M_AXI_LITE_WDATA   (wdata),
        .M_AXI_LITE_WVALID  (wvalid),
        .M_AXI_LITE_WREADY  (s_wready),
        .M_AXI_LITE_BVALID  (s_bvalid),
        .M_AXI_LITE_BREADY  (bready),
        .M_AXI_LITE_ARADDR  (araddr),
        .M_AXI_LITE_ARVALID (arvalid),
        .M_AXI_LITE_ARREADY (s_arready),
        .M_AXI_LITE_RVALID  (s_rvalid),
        .M_AXI_LITE_RREADY  (rready),
        .M_AXI_LITE_RDATA   (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: configurable ready delays, B returned on BREADY alone.
    int          s_aw_dly, s_w_dly;
    bit          s_ar_block, s_b_block;
    int          aw_cnt, w_cnt, aw_hs, w_hs, bready_early, rready_missing;
    bit          aw_got, w_got;
    logic [31:0] s_awaddr_l, s_wdata_l;
    logic [31:0] mem [16];

    always @(posedge clk) begin
        if (rst) begin
            s_awready <= 1'b0; s_wready <= 1'b0; s_bvalid <= 1'b0;
            s_arready <= 1'b0; s_rvalid <= 1'b0; s_rdata <= '0;
            aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            s_awready <= 1'b0;
            if (awvalid && !s_awready && !aw_got) begin
                if (aw_cnt >= s_aw_dly) begin s_awready <= 1'b1; aw_cnt <= 0; end
                else aw_cnt <= aw_cnt + 1;
            end
            if (awvalid && s_awready) begin aw_got <= 1'b1; s_awaddr_l <= awaddr; aw_hs <= aw_hs + 1; end
            s_wready <= 1'b0;
            if (wvalid && !s_wready && !w_got) begin
                if (w_cnt >= s_w_dly) begin s_wready <= 1'b1; w_cnt <= 0; end
                else w_cnt <= w_cnt + 1;
            end
            if (wvalid && s_wready) begin w_got <= 1'b1; s_wdata_l <= wdata; w_hs <= w_hs + 1; end
            if (bready && !(aw_got && w_got)) bready_early <= bready_early + 1;
            s_bvalid <= bready && !s_bvalid && !s_b_block;
            if (s_bvalid && bready) begin
                mem[s_awaddr_l[5:2]] <= s_wdata_l;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end
            s_arready <= arvalid && !s_arready && !s_ar_block;
            if (arvalid && s_arready) begin
                if (!rready) rready_missing <= rready_missing + 1;
                s_rvalid <= 1'b1;
                s_rdata  <= mem[araddr[5:2]];
            end else if (s_rvalid && rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    task automatic set_req(input int i, input bit we, input logic [31:0] a, input logic [31:0] d);
        req_we[i]            = we;
        req_addr[i*32 +: 32]  = a;
        req_wdata[i*32 +: 32] = d;
        req_valid[i]         = 1'b1;
    endtask

    task automatic wait_done(input bit keep, output int idx, output logic err,
                             output logic [31:0] rd, output bit ok);
        ok = 1'b0; idx = -1; err = 1'b0; rd = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (|req_done) begin
                for (int i = 0; i < N; i++) if (req_done[i]) idx = i;
                err = req_err;
                rd  = req_rdata;
                ok  = 1'b1;
                if (!keep) req_valid[idx] = 1'b0;
                break;
            end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL wait_done: no req_done within 400 cycles");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, req_err} !== 7'b0) begin
            failures++; $display("FAIL reset_ctrl: got %b expected 0", {awvalid, wvalid, bready, arvalid, rready, busy, req_err});
        end
        checks++;
        if (req_done !== 4'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", req_done); end
        checks++;
        if (req_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", req_rdata); end
        checks++;
        if ({awaddr, wdata, araddr} !== 96'h0) begin failures++; $display("FAIL reset_bus: got %h expected 0", {awaddr, wdata, araddr}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int idx; logic err; logic [31:0] rd; bit ok; bit seen;
        set_req(0, 1'b1, 32'h04, 32'hA5A5_0001);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (awvalid || wvalid) seen = 1'b1;
        end
        checks++;
        if (!(awvalid === 1'b1 && wvalid === 1'b1)) begin
            failures++; $display("FAIL wr_valid_together: got aw=%b w=%b expected 1 1", awvalid, wvalid);
        end
        checks++;
        if (awaddr !== 32'h04 || wdata !== 32'hA5A5_0001 || busy !== 1'b1) begin
            failures++; $display("FAIL wr_payload: got addr=%h data=%h busy=%b expected 4 a5a50001 1", awaddr, wdata, busy);
        end
        wait_done(1'b0, idx, err, rd, ok);
        checks++;
        if (ok && (idx != 0 || err !== 1'b0 || rd !== 32'h0)) begin
            failures++; $display("FAIL wr_done: got idx=%0d err=%b rd=%h expected 0 0 0", idx, err, rd);
        end
        @(negedge clk);
        checks++;
        if (req_done !== 4'b0) begin failures++; $display("FAIL wr_pulse_width: got %b expected 0", req_done); end
        checks++;
        if (bready_early != 0) begin failures++; $display("FAIL wr_bready_early: got %0d expected 0", bready_early); end
        checks++;
        if (mem[1] !== 32'hA5A5_0001) begin failures++; $display("FAIL wr_mem: got %h expected a5a50001", mem[1]); end
    endtask

    task automatic test_read();
        int idx; logic err; logic [31:0] rd; bit ok; bit seen;
        set_req(2, 1'b0, 32'h04, 32'h0);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (arvalid) seen = 1'b1;
        end
        checks++;
        if (!(arvalid === 1'b1 && rready === 1'b1)) begin
            failures++; $display("FAIL rd_ar_with_rready: got ar=%b r=%b expected 1 1", arvalid, rready);
        end
        wait_done(1'b0, idx, err, rd, ok);
        checks++;
        if (ok && (idx != 2 || err !== 1'b0 || rd !== 32'hA5A5_0001)) begin
            failures++; $display("FAIL rd_done: got idx=%0d err=%b rd=%h expected 2 0 a5a50001", idx, err, rd);
        end
        checks++;
        if (rready_missing != 0) begin failures++; $display("FAIL rd_rready_missing: got %0d expected 0", rready_missing); end
    endtask

    task automatic test_round_robin();
        int idx, prev; logic err; logic [31:0] rd; bit ok;
        int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h04, 32'h0);
        prev = -1;
        for (int t = 0; t < 8; t++) begin
            wait_done(1'b1, idx, err, rd, ok);
            if (t == 7) req_valid = '0;
            checks++;
            if (!ok || idx != exp_order[t] || idx == prev) begin
                failures++; $display("FAIL rr_order[%0d]: got %0d expected %0d", t, idx, exp_order[t]);
            end
            prev = idx;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_skewed_write();
        int idx; logic err; logic [31:0] rd; bit ok; bit fell; int aw0, w0, dones;
        s_aw_dly = 3; s_w_dly = 0;
        aw0 = aw_hs; w0 = w_hs;
        set_req(1, 1'b1, 32'h08, 32'h1234_5678);
        @(negedge clk);
        fell = 1'b0;
        for (int c = 0; c < 20 && !fell; c++) begin
            @(negedge clk);
            if (!wvalid) fell = 1'b1;
        end
        checks++;
        if (!fell || awvalid !== 1'b1) begin
            failures++; $display("FAIL skew_aw_hold: got w=%b aw=%b expected 0 1", wvalid, awvalid);
        end
        wait_done(1'b0, idx, err, rd, ok);
        checks++;
        if (ok && (idx != 1 || err !== 1'b0)) begin
            failures++; $display("FAIL skew_done: got idx=%0d err=%b expected 1 0", idx, err);
        end
        dones = 0;
        repeat (5) begin @(negedge clk); if (|req_done) dones++; end
        checks++;
        if (dones != 0 || aw_hs - aw0 != 1 || w_hs - w0 != 1) begin
            failures++; $display("FAIL skew_single: got extra_done=%0d aw_hs=%0d w_hs=%0d expected 0 1 1", dones, aw_hs - aw0, w_hs - w0);
        end
        checks++;
        if (mem[2] !== 32'h1234_5678 || bready_early != 0) begin
            failures++; $display("FAIL skew_mem: got %h early=%0d expected 12345678 0", mem[2], bready_early);
        end
        s_aw_dly = 0;
    endtask

    task automatic test_timeout();
        int idx, t0; logic err; logic [31:0] rd; bit ok; bit seen;
        s_ar_block = 1'b1;
        set_req(1, 1'b0, 32'h08, 32'h0);
        seen = 1'b0; t0 = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (arvalid) begin seen = 1'b1; t0 = cyc; end
        end
        wait_done(1'b0, idx, err, rd, ok);
        checks++;
        if (ok && cyc - t0 != 255) begin failures++; $display("FAIL tmo_latency: got %0d expected 255", cyc - t0); end
        checks++;
        if (ok && (idx != 1 || err !== 1'b1 || rd !== 32'h0)) begin
            failures++; $display("FAIL tmo_done: got idx=%0d err=%b rd=%h expected 1 1 0", idx, err, rd);
        end
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0) begin
            failures++; $display("FAIL tmo_drop: got ar=%b r=%b expected 0 0", arvalid, rready);
        end
        s_ar_block = 1'b0;
        @(negedge clk);
        set_req(3, 1'b0, 32'h08, 32'h0);
        wait_done(1'b0, idx, err, rd, ok);
        checks++;
        if (ok && (idx != 3 || err !== 1'b0 || rd !== 32'h1234_5678)) begin
            failures++; $display("FAIL tmo_recover: got idx=%0d err=%b rd=%h expected 3 0 12345678", idx, err, rd);
        end
    endtask

    task automatic test_reset_mid_write();
        int idx; logic err; logic [31:0] rd; bit ok; bit seen; int dones;
        s_b_block = 1'b1;
        set_req(1, 1'b1, 32'h0C, 32'hDEAD_BEEF);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bready) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL rst_mid_reach: got bready=%b expected 1", bready); end
        rst = 1'b1;
        req_valid = '0;
        set_req(0, 1'b0, 32'h04, 32'h0);
        set_req(2, 1'b0, 32'h08, 32'h0);
        @(negedge clk);
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, req_err} !== 7'b0 || req_done !== 4'b0) begin
            failures++; $display("FAIL rst_mid_outputs: got ctrl=%b done=%b expected 0 0",
                                 {awvalid, wvalid, bready, arvalid, rready, busy, req_err}, req_done);
        end
        dones = 0;
        repeat (2) begin @(negedge clk); if (|req_done) dones++; end
        checks++;
        if (dones != 0) begin failures++; $display("FAIL rst_mid_no_done: got %0d expected 0", dones); end
        s_b_block = 1'b0;
        rst = 1'b0;
        wait_done(1'b0, idx, err, rd, ok);
        checks++;
        if (ok && (idx != 0 || err !== 1'b0 || rd !== 32'hA5A5_0001)) begin
            failures++; $display("FAIL rst_mid_first_grant: got idx=%0d err=%b rd=%h expected 0 0 a5a50001", idx, err, rd);
        end
        wait_done(1'b0, idx, err, rd, ok);
        checks++;
        if (ok && (idx != 2 || rd !== 32'h1234_5678)) begin
            failures++; $display("FAIL rst_mid_second_grant: got idx=%0d rd=%h expected 2 12345678", idx, rd);
        end
        checks++;
        if (mem[3] !== 32'h0) begin failures++; $display("FAIL rst_mid_aborted_write: got %h expected 0", mem[3]); end
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        s_aw_dly = 0; s_w_dly = 0; s_ar_block = 1'b0; s_b_block = 1'b0;
        aw_hs = 0; w_hs = 0; bready_early = 0; rready_missing = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_skewed_write();
        test_timeout();
        test_reset_mid_write();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
